// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Single-port memory arbiter for a MIPS-style core. Three requesters share
//   one synchronous memory: instruction fetch (read only), MEM-stage data and
//   a debug/loader port. One access is in flight at a time:
//   IDLE (arbitrate) -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack).
//   Priority is dbg > data > fetch, except that a fetch which has lost
//   STARVE_MAX decisions in a row wins over everything.
//
//   Optional feature: define MEM_ARB_DBG_EN to let the debug port arbitrate.
//   Without it the dbg_* inputs are ignored and dbg_ack stays 0.
//
// Ports
//   clk1, rst                          clock, synchronous active-high reset
//   halted                             core halted; fetch requests ignored
//   if_req/if_addr -> if_ack, if_stall instruction fetch port
//   d_req/d_we/d_addr/d_wdata -> d_ack data port
//   dbg_req/dbg_we/dbg_addr/dbg_wdata -> dbg_ack  debug port
//   rdata                              read data, valid while an ack is high
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory side
//   busy                               high in ACCESS or RESP
module mips_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

`ifdef MEM_ARB_DBG_EN
    localparam logic DBG_EN = 1'b1;
`else
    localparam logic DBG_EN = 1'b0;
`endif

    localparam logic [1:0] LAT_LAST   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_D, SRC_DBG} src_t;

    state_t     state, state_nxt;
    src_t       win, gnt;
    logic [1:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       we_q;
    logic       if_elig, d_elig, dbg_elig, last_acc;

    assign if_elig  = if_req & ~halted;
    assign d_elig   = d_req;
    // With the debug port compiled out this term is constant 0.
    assign dbg_elig = dbg_req & DBG_EN;
    assign last_acc = (lat_cnt == LAT_LAST);

    // Winner of the current IDLE decision; the starvation override comes first.
    always_comb begin
        win = SRC_NONE;
        if (if_elig && (starve_cnt == STARVE_LIM)) win = SRC_IF;
        else if (dbg_elig)                         win = SRC_DBG;
        else if (d_elig)                           win = SRC_D;
        else if (if_elig)                          win = SRC_IF;
    end

    // State register
    always_ff @(posedge clk1) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win != SRC_NONE) state_nxt = ACCESS;
            ACCESS:  if (last_acc)        state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, latency counter, starvation counter and read data.
    always_ff @(posedge clk1) begin
        if (rst) begin
            gnt        <= SRC_NONE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win != SRC_NONE) begin
                        gnt     <= win;
                        lat_cnt <= '0;
                        case (win)
                            SRC_DBG: begin
                                mem_addr  <= dbg_addr;
                                we_q      <= dbg_we;
                                mem_wdata <= dbg_wdata;
                            end
                            SRC_D: begin
                                mem_addr  <= d_addr;
                                we_q      <= d_we;
                                mem_wdata <= d_wdata;
                            end
                            default: begin
                                // Fetch is read-only; write data is left as is.
                                mem_addr <= if_addr;
                                we_q     <= 1'b0;
                            end
                        endcase
                        // Counts lost decisions only; saturates at the limit.
                        if (win == SRC_IF)
                            starve_cnt <= '0;
                        else if (if_elig && (starve_cnt < STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    // Memory data is valid in the last ACCESS cycle only.
                    if (last_acc && !we_q) rdata <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and the captured grant
    always_comb begin
        mem_en  = (state == ACCESS);
        mem_we  = (state == ACCESS) & we_q;
        busy    = (state != IDLE);
        if_ack  = (state == RESP) && (gnt == SRC_IF);
        d_ack   = (state == RESP) && (gnt == SRC_D);
        dbg_ack = DBG_EN && (state == RESP) && (gnt == SRC_DBG);
    end

    assign if_stall = if_req & ~if_ack;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter (MEM_LAT=2, STARVE_MAX=3).
// Expected acknowledges are queued when a scenario is driven and compared,
// in order, whenever the arbiter raises an ack. Works with or without
// MEM_ARB_DBG_EN defined.
module tb_mips_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    localparam int SRC_IF  = 1;
    localparam int SRC_D   = 2;
    localparam int SRC_DBG = 3;

    localparam logic [31:0] V5  = 32'h2801000A;
    localparam logic [31:0] V6  = 32'h8C220004;
    localparam logic [31:0] V20 = 32'hAC430010;
    localparam logic [31:0] VDB = 32'hFC000000;
    localparam logic [31:0] VDW = 32'h12345678;

    logic          clk1 = 1'b0;
    logic          rst, halted;
    logic          if_req, if_ack, if_stall;
    logic [AW-1:0] if_addr;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(3)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    // Memory model: asynchronous read, writes on the clock edge.
    logic [DW-1:0] mem [0:1023];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk1) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        else if (ld_en)       mem[ld_addr] <= ld_data;
    end

    typedef struct {
        int          who;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnum = 0;
    int   t0 = 0;
    bit   if_hold = 0, d_hold = 0;
    bit   drop_if = 0, drop_d = 0, drop_dbg = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ack(input int who, input logic [31:0] data, input int cyc);
        exp_t e;
        e.who  = who;
        e.data = data;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    // Falling edge: score any ack against the queue head.
    task automatic neg();
        exp_t e;
        int   who;
        @(negedge clk1);
        if (if_ack || d_ack || dbg_ack) begin
            who = dbg_ack ? SRC_DBG : (d_ack ? SRC_D : SRC_IF);
            chk("ack_onehot", 32'($countones({if_ack, d_ack, dbg_ack})), 32'd1);
            if (sb.size() == 0) begin
                chk("ack_unexpected", 32'(who), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_src", 32'(who), 32'(e.who));
                chk("ack_cycle", 32'(cnum - t0), 32'(e.cyc));
                chk("ack_rdata", rdata, e.data);
            end
            if (if_ack)  drop_if  = 1;
            if (d_ack)   drop_d   = 1;
            if (dbg_ack) drop_dbg = 1;
        end
    endtask

    // Just after the rising edge: requesters release after their ack.
    task automatic pos();
        @(posedge clk1);
        #1;
        cnum++;
        if (drop_if && !if_hold) if_req = 0;
        if (drop_d && !d_hold)   d_req = 0;
        if (drop_dbg)            dbg_req = 0;
        drop_if = 0; drop_d = 0; drop_dbg = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin neg(); pos(); end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            neg(); pos(); n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ld_en = 1; ld_addr = a; ld_data = v;
        pos();
        ld_en = 0;
    endtask

    initial begin
        rst = 1; halted = 0;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) pos();
        rst = 0;

        // Reset state
        neg();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, dbg_ack}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        pos();

        load(10'd5, V5);
        load(10'd6, V6);
        load(10'd20, V20);
        load(10'd8, 32'd0);
        load(10'd9, 32'd0);
        idle(1);

        // Single fetch read
        if_req = 1; if_addr = 10'd5; t0 = cnum;
        expect_ack(SRC_IF, V5, 3);
        for (int c = 0; c < 4; c++) begin
            neg();
            chk("f_mem_en", 32'(mem_en), 32'(c == 1 || c == 2));
            chk("f_busy", 32'(busy), 32'(c >= 1));
            chk("f_stall", 32'(if_stall), 32'(c <= 2));
            if (c == 1) begin
                chk("f_mem_addr", 32'(mem_addr), 32'd5);
                chk("f_mem_we", 32'(mem_we), 32'd0);
            end
            pos();
        end
        chk("f_sb_empty", 32'(sb.size()), 32'd0);
        idle(2);

        // Fetch and data read presented together
        if_req = 1; if_addr = 10'd6; d_req = 1; d_we = 0; d_addr = 10'd20; t0 = cnum;
        expect_ack(SRC_D, V20, 3);
        expect_ack(SRC_IF, V6, 7);
        for (int c = 0; c < 8; c++) begin
            neg();
            chk("fd_stall", 32'(if_stall), 32'(c < 7));
            pos();
        end
        chk("fd_sb_empty", 32'(sb.size()), 32'd0);
        idle(2);

        // Continuous data requests starve fetch for three grants only
        if_hold = 1; d_hold = 1;
        if_req = 1; if_addr = 10'd6; d_req = 1; d_we = 0; d_addr = 10'd20; t0 = cnum;
        for (int k = 0; k < 2; k++) begin
            expect_ack(SRC_D, V20, 16 * k + 3);
            expect_ack(SRC_D, V20, 16 * k + 7);
            expect_ack(SRC_D, V20, 16 * k + 11);
            expect_ack(SRC_IF, V6, 16 * k + 15);
        end
        wait_drain(40);
        if_hold = 0; d_hold = 0; if_req = 0; d_req = 0;
        idle(2);

        // Debug write contending with data and fetch
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'd8; dbg_wdata = VDB;
        d_req = 1; d_we = 0; d_addr = 10'd20;
        if_req = 1; if_addr = 10'd6; t0 = cnum;
`ifdef MEM_ARB_DBG_EN
        expect_ack(SRC_DBG, V6, 3);
        expect_ack(SRC_D, V20, 7);
        expect_ack(SRC_IF, V6, 11);
`else
        expect_ack(SRC_D, V20, 3);
        expect_ack(SRC_IF, V6, 7);
`endif
        for (int c = 0; c < 12; c++) begin
            neg();
            if (c == 1) begin
`ifdef MEM_ARB_DBG_EN
                chk("dbg_mem_we", 32'(mem_we), 32'd1);
                chk("dbg_mem_wdata", mem_wdata, VDB);
                chk("dbg_mem_addr", 32'(mem_addr), 32'd8);
`else
                chk("nodbg_mem_we", 32'(mem_we), 32'd0);
                chk("nodbg_mem_addr", 32'(mem_addr), 32'd20);
`endif
            end
            pos();
        end
        chk("dbg_sb_empty", 32'(sb.size()), 32'd0);
`ifdef MEM_ARB_DBG_EN
        chk("dbg_mem8", mem[8], VDB);
`else
        chk("nodbg_mem8", mem[8], 32'd0);
`endif
        dbg_req = 0; dbg_we = 0; d_req = 0; if_req = 0;
        idle(2);

        // Data write leaves rdata untouched
        d_req = 1; d_we = 1; d_addr = 10'd9; d_wdata = VDW; t0 = cnum;
        expect_ack(SRC_D, V6, 3);
        for (int c = 0; c < 4; c++) begin
            neg();
            if (c == 1) begin
                chk("dw_mem_we", 32'(mem_we), 32'd1);
                chk("dw_mem_wdata", mem_wdata, VDW);
            end
            pos();
        end
        chk("dw_sb_empty", 32'(sb.size()), 32'd0);
        chk("dw_mem9", mem[9], VDW);
        d_we = 0; d_req = 0;
        idle(2);

        // Reset in the first ACCESS cycle aborts the transfer without an ack
        if_req = 1; if_addr = 10'd5; t0 = cnum;
        for (int c = 0; c < 6; c++) begin
            neg();
            if (c == 1) chk("ra_busy_before", 32'(busy), 32'd1);
            if (c >= 2) begin
                chk("ra_mem_en", 32'(mem_en), 32'd0);
                chk("ra_busy", 32'(busy), 32'd0);
                chk("ra_acks", 32'({if_ack, d_ack, dbg_ack}), 32'd0);
            end
            if (c == 2) begin
                chk("ra_rdata", rdata, 32'd0);
                chk("ra_mem_addr", 32'(mem_addr), 32'd0);
            end
            pos();
            if (c == 0) rst = 1;
            if (c == 1) begin rst = 0; if_req = 0; end
        end

        // Halted core: fetch is never granted
        halted = 1; if_req = 1; if_addr = 10'd6;
        for (int c = 0; c < 6; c++) begin
            neg();
            chk("h_mem_en", 32'(mem_en), 32'd0);
            chk("h_busy", 32'(busy), 32'd0);
            chk("h_stall", 32'(if_stall), 32'd1);
            pos();
        end
        // Released, then halted again mid-fetch: the fetch still completes
        halted = 0; t0 = cnum;
        expect_ack(SRC_IF, V6, 3);
        for (int c = 0; c < 4; c++) begin
            neg();
            if (c == 1) chk("h_busy_granted", 32'(busy), 32'd1);
            pos();
            if (c == 0) halted = 1;
        end
        chk("h_sb_empty", 32'(sb.size()), 32'd0);
        halted = 0; if_req = 0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
